// File: rtl/vga_timing_rx.sv
// vga_timing_rx: watches an hsync/vsync/blank_n stream, measures line and
// frame timing, recovers pixel coordinates and reports lock to a stable raster.
module vga_timing_rx #(
  parameter int CNT_W        = 12,
  parameter int LOCK_FRAMES  = 2,
  parameter int SYNC_ACT_LOW = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hsync_in,
  input  logic             vsync_in,
  input  logic             blank_n_in,
  output logic             de,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             frame_start,
  output logic [CNT_W-1:0] h_total,
  output logic [CNT_W-1:0] v_total,
  output logic [CNT_W-1:0] h_sync_w,
  output logic [CNT_W-1:0] v_sync_w,
  output logic [CNT_W-1:0] h_active,
  output logic [CNT_W-1:0] v_active,
  output logic             locked,
  output logic             timing_error
);
  typedef logic [CNT_W-1:0] cnt_t;
  localparam cnt_t       CNT_MAX = '1;
  localparam logic [7:0] LOCK_N  = 8'(LOCK_FRAMES);

  typedef enum logic [1:0] {SEARCH, CHECK, LOCKED} state_t;

  function automatic cnt_t inc_sat(input cnt_t v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  logic hs_n, vs_n;
  assign hs_n = (SYNC_ACT_LOW != 0) ? ~hsync_in : hsync_in;
  assign vs_n = (SYNC_ACT_LOW != 0) ? ~vsync_in : vsync_in;

  logic hs_q, hs_d, vs_q, vs_d, bl_q, bl_d, hs_p_q, hs_p_d, vs_p_q, vs_p_d;
  cnt_t hcnt_q, hcnt_d, vcnt_q, vcnt_d, hsw_cnt_q, hsw_cnt_d, vsw_cnt_q, vsw_cnt_d;
  cnt_t act_cnt_q, act_cnt_d, vact_cnt_q, vact_cnt_d, first_len_q, first_len_d;
  cnt_t x_q, x_d, y_q, y_d;
  cnt_t h_total_q, h_total_d, v_total_q, v_total_d, h_sync_w_q, h_sync_w_d;
  cnt_t v_sync_w_q, v_sync_w_d, h_active_q, h_active_d, v_active_q, v_active_d;
  logic line_act_q, line_act_d, first_pend_q, first_pend_d, frame_mis_q, frame_mis_d;
  logic y_first_q, y_first_d, frame_start_q, frame_start_d;

  state_t     state_q;
  logic [7:0] match_cnt_q;
  logic       meas_valid_q, locked_q, timing_error_q;
  cnt_t       ref_h_q, ref_v_q;

  logic hs_rise, hs_fall, vs_rise, vs_fall, hcnt_sat, line_ok, mis_now;
  cnt_t line_len, h_now, v_now, vact_closed;

  assign hs_rise  = hs_q & ~hs_p_q;
  assign hs_fall  = ~hs_q & hs_p_q;
  assign vs_rise  = vs_q & ~vs_p_q;
  assign vs_fall  = ~vs_q & vs_p_q;
  assign hcnt_sat = (hcnt_q == CNT_MAX);
  assign line_len = inc_sat(hcnt_q);
  // A line that ran into saturation is never a valid measurement.
  assign line_ok  = hs_rise & ~hcnt_sat;
  // Values as they stand once a coincident line close has been applied,
  // so the frame decision sees the line that ends on the vsync edge.
  assign h_now       = line_ok ? line_len : h_total_q;
  assign v_now       = hs_rise ? inc_sat(vcnt_q) : vcnt_q;
  assign vact_closed = (hs_rise && line_act_q) ? inc_sat(vact_cnt_q) : vact_cnt_q;
  assign mis_now     = frame_mis_q | (line_ok & ~first_pend_q & (line_len != first_len_q));

  // Next-state for the input stage, measurement counters and coordinates.
  always_comb begin
    hs_d = hs_n;  vs_d = vs_n;  bl_d = blank_n_in;
    hs_p_d = hs_q;  vs_p_d = vs_q;
    hcnt_d = hs_rise ? '0 : inc_sat(hcnt_q);
    vcnt_d = vcnt_q;  hsw_cnt_d = hsw_cnt_q;  vsw_cnt_d = vsw_cnt_q;
    act_cnt_d = act_cnt_q;  vact_cnt_d = vact_cnt_q;  line_act_d = line_act_q;
    first_len_d = first_len_q;  first_pend_d = first_pend_q;  frame_mis_d = frame_mis_q;
    h_total_d = h_total_q;  v_total_d = v_total_q;  h_sync_w_d = h_sync_w_q;
    v_sync_w_d = v_sync_w_q;  h_active_d = h_active_q;  v_active_d = v_active_q;
    x_d = x_q;  y_d = y_q;  y_first_d = y_first_q;  frame_start_d = 1'b0;

    if (line_ok) h_total_d = line_len;

    if (hs_rise) hsw_cnt_d = cnt_t'(1);
    else if (hs_q) hsw_cnt_d = inc_sat(hsw_cnt_q);
    if (hs_fall) h_sync_w_d = hsw_cnt_q;

    // Blank lines leave h_active holding the last active line's width.
    if (hs_rise) begin
      if (line_ok && act_cnt_q != '0) h_active_d = act_cnt_q;
      act_cnt_d  = bl_q ? cnt_t'(1) : '0;
      vcnt_d     = inc_sat(vcnt_q);
      vact_cnt_d = vact_closed;
      line_act_d = bl_q;
    end else if (bl_q) begin
      act_cnt_d  = inc_sat(act_cnt_q);
      line_act_d = 1'b1;
    end

    if (line_ok) begin
      if (first_pend_q) begin
        first_len_d  = line_len;
        first_pend_d = 1'b0;
      end else if (line_len != first_len_q) begin
        frame_mis_d = 1'b1;
      end
    end

    // The frame closes after the line, so these override the line updates.
    if (vs_rise) begin
      vsw_cnt_d = hs_rise ? cnt_t'(1) : '0;
      if (!hcnt_sat) begin
        v_total_d  = v_now;
        v_active_d = vact_closed;
      end
      vcnt_d       = '0;
      vact_cnt_d   = '0;
      first_pend_d = 1'b1;
      frame_mis_d  = 1'b0;
      y_first_d    = 1'b1;
    end else if (vs_q && hs_rise) begin
      vsw_cnt_d = inc_sat(vsw_cnt_q);
    end
    if (vs_fall) v_sync_w_d = vsw_cnt_q;

    // Coordinates come from the raw blank so they line up with de.
    if (blank_n_in && !bl_q) begin
      x_d = '0;
      if (y_first_q || vs_rise) begin
        y_d           = '0;
        y_first_d     = 1'b0;
        frame_start_d = 1'b1;
      end else begin
        y_d = inc_sat(y_q);
      end
    end else if (blank_n_in) begin
      x_d = inc_sat(x_q);
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hs_q <= 1'b0;  vs_q <= 1'b0;  bl_q <= 1'b0;  hs_p_q <= 1'b0;  vs_p_q <= 1'b0;
      hcnt_q <= '0;  vcnt_q <= '0;  hsw_cnt_q <= '0;  vsw_cnt_q <= '0;
      act_cnt_q <= '0;  vact_cnt_q <= '0;  line_act_q <= 1'b0;
      first_len_q <= '0;  first_pend_q <= 1'b0;  frame_mis_q <= 1'b0;
      h_total_q <= '0;  v_total_q <= '0;  h_sync_w_q <= '0;
      v_sync_w_q <= '0;  h_active_q <= '0;  v_active_q <= '0;
      x_q <= '0;  y_q <= '0;  y_first_q <= 1'b0;  frame_start_q <= 1'b0;
    end else begin
      hs_q <= hs_d;  vs_q <= vs_d;  bl_q <= bl_d;  hs_p_q <= hs_p_d;  vs_p_q <= vs_p_d;
      hcnt_q <= hcnt_d;  vcnt_q <= vcnt_d;  hsw_cnt_q <= hsw_cnt_d;  vsw_cnt_q <= vsw_cnt_d;
      act_cnt_q <= act_cnt_d;  vact_cnt_q <= vact_cnt_d;  line_act_q <= line_act_d;
      first_len_q <= first_len_d;  first_pend_q <= first_pend_d;  frame_mis_q <= frame_mis_d;
      h_total_q <= h_total_d;  v_total_q <= v_total_d;  h_sync_w_q <= h_sync_w_d;
      v_sync_w_q <= v_sync_w_d;  h_active_q <= h_active_d;  v_active_q <= v_active_d;
      x_q <= x_d;  y_q <= y_d;  y_first_q <= y_first_d;  frame_start_q <= frame_start_d;
    end
  end

  // Lock FSM: qualifies successive frames against a stored reference.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SEARCH;  match_cnt_q <= '0;  meas_valid_q <= 1'b0;
      ref_h_q <= '0;  ref_v_q <= '0;  locked_q <= 1'b0;  timing_error_q <= 1'b0;
    end else begin
      timing_error_q <= 1'b0;
      if (hcnt_sat) begin
        timing_error_q <= (state_q == LOCKED);
        state_q        <= SEARCH;
        locked_q       <= 1'b0;
        meas_valid_q   <= 1'b0;
        match_cnt_q    <= '0;
      end else begin
        case (state_q)
          SEARCH: if (vs_rise) begin
            state_q      <= CHECK;
            match_cnt_q  <= '0;
            meas_valid_q <= 1'b0;
          end
          CHECK: if (vs_rise) begin
            if (!meas_valid_q) begin
              ref_h_q      <= h_now;
              ref_v_q      <= v_now;
              meas_valid_q <= 1'b1;
              match_cnt_q  <= '0;
            end else if (h_now == ref_h_q && v_now == ref_v_q && !mis_now) begin
              match_cnt_q <= match_cnt_q + 8'd1;
              if (match_cnt_q + 8'd1 >= LOCK_N) begin
                state_q  <= LOCKED;
                locked_q <= 1'b1;
              end
            end else begin
              ref_h_q     <= h_now;
              ref_v_q     <= v_now;
              match_cnt_q <= '0;
            end
          end
          LOCKED: if ((line_ok && line_len != ref_h_q) || (vs_rise && v_now != ref_v_q)) begin
            timing_error_q <= 1'b1;
            locked_q       <= 1'b0;
            state_q        <= CHECK;
            meas_valid_q   <= 1'b0;
            match_cnt_q    <= '0;
          end
          default: state_q <= SEARCH;
        endcase
      end
    end
  end

  assign de           = bl_q;
  assign x            = x_q;
  assign y            = y_q;
  assign frame_start  = frame_start_q;
  assign h_total      = h_total_q;
  assign v_total      = v_total_q;
  assign h_sync_w     = h_sync_w_q;
  assign v_sync_w     = v_sync_w_q;
  assign h_active     = h_active_q;
  assign v_active     = v_active_q;
  assign locked       = locked_q;
  assign timing_error = timing_error_q;
endmodule

// File: tb/tb_vga_timing_rx.sv
// Bench for vga_timing_rx: a reduced raster drives an active-low instance and
// an active-high instance side by side; expected values are raster constants.
module tb_vga_timing_rx;
  localparam int W = 12;
  localparam int H_TOT = 50, HSW = 8, HA0 = 12, HACT = 32;
  localparam int V_TOT = 14, VSW = 3, VA0 = 4, VACT = 8;

  logic clk = 1'b0, rst = 1'b1;
  logic hsync_a = 1'b1, vsync_a = 1'b1, hsync_b = 1'b0, vsync_b = 1'b0, blank_n = 1'b0;
  logic de_a, fs_a, locked_a, te_a, de_b, fs_b, locked_b, te_b;
  logic [W-1:0] x_a, y_a, ht_a, vt_a, hsw_a, vsw_a, ha_a, va_a;
  logic [W-1:0] x_b, y_b, ht_b, vt_b, hsw_b, vsw_b, ha_b, va_b;

  int errors = 0, checks = 0, cyc = 0, frame_cyc = 0;
  int te_cnt_a = 0, te_cnt_b = 0, te_cyc_a = -1, lock_rise_a = -1, lock_rise_b = -1;
  int fs_cnt = 0, fs_cyc = -1;
  logic prev_lock_a = 1'b0, prev_lock_b = 1'b0, fs_de = 1'b0;
  logic [W-1:0] fs_x = '0, fs_y = '0, last_x = '0, last_y = '0;

  always #5 clk = ~clk;

  vga_timing_rx dut_a (
    .clk(clk), .rst(rst), .hsync_in(hsync_a), .vsync_in(vsync_a), .blank_n_in(blank_n),
    .de(de_a), .x(x_a), .y(y_a), .frame_start(fs_a), .h_total(ht_a), .v_total(vt_a),
    .h_sync_w(hsw_a), .v_sync_w(vsw_a), .h_active(ha_a), .v_active(va_a),
    .locked(locked_a), .timing_error(te_a));

  vga_timing_rx #(.SYNC_ACT_LOW(0)) dut_b (
    .clk(clk), .rst(rst), .hsync_in(hsync_b), .vsync_in(vsync_b), .blank_n_in(blank_n),
    .de(de_b), .x(x_b), .y(y_b), .frame_start(fs_b), .h_total(ht_b), .v_total(vt_b),
    .h_sync_w(hsw_b), .v_sync_w(vsw_b), .h_active(ha_b), .v_active(va_b),
    .locked(locked_b), .timing_error(te_b));

  // One pixel: sample outputs at the falling edge, then drive the next inputs.
  task automatic drive_cycle(input logic hs, input logic vs, input logic bl);
    @(negedge clk);
    if (te_a) begin te_cnt_a++; te_cyc_a = cyc; end
    if (te_b) te_cnt_b++;
    if (locked_a && !prev_lock_a) lock_rise_a = cyc;
    if (locked_b && !prev_lock_b) lock_rise_b = cyc;
    prev_lock_a = locked_a;
    prev_lock_b = locked_b;
    if (fs_a) begin fs_cnt++; fs_cyc = cyc; fs_x = x_a; fs_y = y_a; fs_de = de_a; end
    if (de_a) begin last_x = x_a; last_y = y_a; end
    hsync_a = ~hs;  vsync_a = ~vs;  hsync_b = hs;  vsync_b = vs;  blank_n = bl;
    cyc++;
  endtask

  task automatic drive_frame(input int short_line, input int max_cyc);
    int n = 0;
    frame_cyc = cyc;
    for (int l = 0; l < V_TOT; l++) begin
      for (int h = 0; h < ((l == short_line) ? H_TOT - 1 : H_TOT); h++) begin
        if (n < max_cyc)
          drive_cycle(h < HSW, l < VSW,
                      (l >= VA0) && (l < VA0 + VACT) && (h >= HA0) && (h < HA0 + HACT));
        n++;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({de_a, fs_a, locked_a, te_a, x_a, y_a} !== '0) begin
      errors++; $display("FAIL reset_flags_a: got %0h expected 0", {de_a, fs_a, locked_a, te_a, x_a, y_a});
    end
    checks++;
    if ({ht_a, vt_a, hsw_a, vsw_a, ha_a, va_a} !== '0) begin
      errors++; $display("FAIL reset_meas_a: got %0h expected 0", {ht_a, vt_a, hsw_a, vsw_a, ha_a, va_a});
    end
    checks++;
    if ({de_b, fs_b, locked_b, te_b, x_b, y_b, ht_b, vt_b, hsw_b, vsw_b, ha_b, va_b} !== '0) begin
      errors++; $display("FAIL reset_all_b: got %0h expected 0", {locked_b, ht_b, vt_b});
    end
    rst = 1'b0;
    for (int i = 0; i < 5; i++) drive_cycle(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_lock;
    int f3;
    lock_rise_a = -1;  lock_rise_b = -1;  f3 = 0;
    for (int k = 0; k < 4; k++) begin
      drive_frame(-1, H_TOT * V_TOT);
      if (k == 3) f3 = frame_cyc;
    end
    checks++;
    if (lock_rise_a !== f3 + 2) begin
      errors++; $display("FAIL lock_time_a: got %0d expected %0d", lock_rise_a, f3 + 2);
    end
    checks++;
    if (lock_rise_b !== f3 + 2) begin
      errors++; $display("FAIL lock_time_b: got %0d expected %0d", lock_rise_b, f3 + 2);
    end
    checks++; if (ht_a !== 12'd50) begin errors++; $display("FAIL h_total: got %0d expected 50", ht_a); end
    checks++; if (hsw_a !== 12'd8) begin errors++; $display("FAIL h_sync_w: got %0d expected 8", hsw_a); end
    checks++; if (ha_a !== 12'd32) begin errors++; $display("FAIL h_active: got %0d expected 32", ha_a); end
    checks++; if (vt_a !== 12'd14) begin errors++; $display("FAIL v_total: got %0d expected 14", vt_a); end
    checks++; if (vsw_a !== 12'd3) begin errors++; $display("FAIL v_sync_w: got %0d expected 3", vsw_a); end
    checks++; if (va_a !== 12'd8) begin errors++; $display("FAIL v_active: got %0d expected 8", va_a); end
    checks++;
    if ({ht_b, hsw_b, ha_b, vt_b, vsw_b, va_b} !== {12'd50, 12'd8, 12'd32, 12'd14, 12'd3, 12'd8}) begin
      errors++; $display("FAIL meas_b: got %0d/%0d/%0d/%0d/%0d/%0d expected 50/8/32/14/3/8",
                         ht_b, hsw_b, ha_b, vt_b, vsw_b, va_b);
    end
  endtask

  task automatic test_coords;
    int fs0, te0;
    fs0 = fs_cnt;  te0 = te_cnt_a;
    drive_frame(-1, H_TOT * V_TOT);
    checks++;
    if (fs_cnt - fs0 !== 1) begin errors++; $display("FAIL frame_start_count: got %0d expected 1", fs_cnt - fs0); end
    checks++;
    if (fs_cyc - frame_cyc !== VA0 * H_TOT + HA0 + 1) begin
      errors++; $display("FAIL frame_start_pos: got %0d expected %0d", fs_cyc - frame_cyc, VA0 * H_TOT + HA0 + 1);
    end
    checks++;
    if ({fs_de, fs_x, fs_y} !== {1'b1, 12'd0, 12'd0}) begin
      errors++; $display("FAIL first_pixel: got de=%0d x=%0d y=%0d expected de=1 x=0 y=0", fs_de, fs_x, fs_y);
    end
    checks++;
    if ({last_x, last_y} !== {12'd31, 12'd7}) begin
      errors++; $display("FAIL last_pixel: got x=%0d y=%0d expected x=31 y=7", last_x, last_y);
    end
    checks++;
    if ({locked_a, te_cnt_a - te0} !== {1'b1, 32'd0}) begin
      errors++; $display("FAIL stay_locked: got locked=%0d errs=%0d expected 1/0", locked_a, te_cnt_a - te0);
    end
  endtask

  task automatic test_short_line;
    int te0a, te0b, fl;
    te0a = te_cnt_a;  te0b = te_cnt_b;  fl = 0;
    drive_frame(5, H_TOT * V_TOT);
    checks++;
    if (te_cnt_a - te0a !== 1) begin errors++; $display("FAIL err_pulses_a: got %0d expected 1", te_cnt_a - te0a); end
    checks++;
    if (te_cnt_b - te0b !== 1) begin errors++; $display("FAIL err_pulses_b: got %0d expected 1", te_cnt_b - te0b); end
    checks++;
    if (te_cyc_a !== frame_cyc + 6 * H_TOT - 1 + 2) begin
      errors++; $display("FAIL err_time: got %0d expected %0d", te_cyc_a, frame_cyc + 6 * H_TOT + 1);
    end
    checks++;
    if (locked_a !== 1'b0) begin errors++; $display("FAIL unlock_after_err: got %0d expected 0", locked_a); end
    lock_rise_a = -1;  lock_rise_b = -1;
    for (int k = 0; k < 3; k++) begin
      drive_frame(-1, H_TOT * V_TOT);
      if (k == 2) fl = frame_cyc;
    end
    checks++;
    if (lock_rise_a !== fl + 2) begin errors++; $display("FAIL relock_a: got %0d expected %0d", lock_rise_a, fl + 2); end
    checks++;
    if (lock_rise_b !== fl + 2) begin errors++; $display("FAIL relock_b: got %0d expected %0d", lock_rise_b, fl + 2); end
  endtask

  task automatic test_reset_mid;
    int f3;
    f3 = 0;
    drive_frame(-1, 300);
    checks++;
    if (locked_a !== 1'b1) begin errors++; $display("FAIL locked_before_rst: got %0d expected 1", locked_a); end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({de_a, fs_a, locked_a, te_a, x_a, y_a, ht_a, vt_a, hsw_a, vsw_a, ha_a, va_a} !== '0) begin
      errors++; $display("FAIL async_rst_a: got locked=%0d x=%0d y=%0d h_total=%0d expected all 0", locked_a, x_a, y_a, ht_a);
    end
    checks++;
    if ({locked_b, ht_b, vt_b} !== '0) begin
      errors++; $display("FAIL async_rst_b: got locked=%0d h_total=%0d expected 0", locked_b, ht_b);
    end
    hsync_a = 1'b1;  vsync_a = 1'b1;  hsync_b = 1'b0;  vsync_b = 1'b0;  blank_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    lock_rise_a = -1;  lock_rise_b = -1;
    for (int k = 0; k < 4; k++) begin
      drive_frame(-1, H_TOT * V_TOT);
      if (k == 3) f3 = frame_cyc;
    end
    checks++;
    if (lock_rise_a !== f3 + 2) begin errors++; $display("FAIL rst_relock_a: got %0d expected %0d", lock_rise_a, f3 + 2); end
    checks++;
    if (lock_rise_b !== f3 + 2) begin errors++; $display("FAIL rst_relock_b: got %0d expected %0d", lock_rise_b, f3 + 2); end
  endtask

  task automatic test_timeout;
    int te0a, te0b;
    te0a = te_cnt_a;  te0b = te_cnt_b;
    for (int i = 0; i < 4200; i++) drive_cycle(1'b0, 1'b0, 1'b0);
    checks++;
    if (te_cnt_a - te0a !== 1) begin errors++; $display("FAIL timeout_err_a: got %0d expected 1", te_cnt_a - te0a); end
    checks++;
    if (te_cnt_b - te0b !== 1) begin errors++; $display("FAIL timeout_err_b: got %0d expected 1", te_cnt_b - te0b); end
    checks++;
    if ({locked_a, locked_b} !== 2'b00) begin
      errors++; $display("FAIL timeout_unlock: got %0d%0d expected 00", locked_a, locked_b);
    end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_coords();
    test_short_line();
    test_reset_mid();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
